branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipelined CPU. It replaces the fixed "fetch PC+4, redirect when the branch resolves in ID" scheme with a direct-mapped branch target buffer (BTB) whose entries each hold a 2-bit saturating direction counter. Fetch queries it combinationally with the current PC to obtain the next PC. Decode reports each resolved branch or jump back, so the predictor can train and flag mispredictions for a pipeline flush.

## Interface
Parameters:
- ENTRIES, 16 — number of BTB entries; power of two, ≥2.
- ADDR_W, 32 — PC and target width.
- STAT_W, 16 — width of the saturating statistics counters.
- Derived: IDX_W = log2(ENTRIES); TAG_W = ADDR_W − IDX_W − 2.

Ports:
- CLOCK  in  1 — single clock; all state updates on the rising edge.
- RESET  in  1 — synchronous, active-high.
- LookupPC  in  ADDR_W — fetch-stage PC.
- PredTaken  out  1 — prediction for LookupPC: taken.
- PredNextPC  out  ADDR_W — next fetch PC: BTB target if PredTaken, else LookupPC+4.
- UpdateEN  in  1 — a branch or jump resolved this cycle.
- UpdatePC  in  ADDR_W — PC of the resolved instruction.
- UpdateIsJump  in  1 — the resolved instruction is an unconditional j/jal.
- UpdateTaken  in  1 — actual direction.
- UpdateTarget  in  ADDR_W — actual target.
- UpdatePredTaken  in  1 — prediction made at fetch, carried down the pipe.
- UpdatePredNextPC  in  ADDR_W — next PC predicted at fetch, carried down the pipe.
- Mispredict  out  1 — flush request for the fetch/decode stages.
- RecoverPC  out  ADDR_W — correct next PC when Mispredict=1.
- UpdateCount  out  STAT_W — number of resolved updates, saturating.
- MispredCount  out  STAT_W — number of mispredictions, saturating.

## Operation
- Index = PC[IDX_W+1:2]; tag = PC[ADDR_W−1:IDX_W+2].
- Entry fields: valid, tag, target, ctr[1:0]. Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational):
  - hit = valid[idx] && tag match.
  - PredTaken = hit && ctr[1].
  - PredNextPC = PredTaken ? target : LookupPC+4, computed modulo 2^ADDR_W.
- Update on UpdateEN=1:
  - **Hit, conditional branch:** ctr increments if UpdateTaken, else decrements, saturating at 11 and 00. When UpdateTaken=1, target is overwritten with UpdateTarget.
  - **Hit, jump:** ctr←11 and target←UpdateTarget.
  - **Miss, UpdateTaken=1:** allocate the entry, evicting any occupant. Set valid←1, tag, target, and ctr←11 for a jump or 10 for a branch.
  - **Miss, UpdateTaken=0:** no allocation; table unchanged.
- Mispredict = UpdateEN && (UpdatePredNextPC ≠ (UpdateTaken ? UpdateTarget : UpdatePC+4)). This covers both direction and target errors.
- RecoverPC = UpdateTaken ? UpdateTarget : UpdatePC+4. It is always driven; it is meaningful only when Mispredict=1.
- Statistics:
  - UpdateCount increments on every UpdateEN.
  - MispredCount increments on every Mispredict.
  - Both hold at 2^STAT_W−1.

## Timing
- Lookup has zero latency: outputs are combinational from LookupPC and the current table state.
- Updates take effect at the rising edge of the update cycle and are visible to lookups from the next cycle.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update entry; there is no bypass.
- Mispredict and RecoverPC are combinational in the update cycle. The consumer flushes IF/ID and loads RecoverPC at that edge.
- Reset, on an edge with RESET=1:
  - All valid←0 and all ctr←01.
  - UpdateCount=0 and MispredCount=0.
  - Outputs then read PredTaken=0 and PredNextPC=LookupPC+4.
  - Reset takes priority over a simultaneous UpdateEN; the update is discarded.
- Targets need not be cleared on reset; they are unobservable while valid=0.

## Structure
- Shared package cpu_pkg holds:
  - counter encodings CTR_SNT / CTR_WNT / CTR_WT / CTR_ST;
  - the reset counter value CTR_WNT;
  - the BTB entry struct typedef.
- Sub-module sat_counter2: 2-bit next-state function (in, taken, force_strong → out). It is instantiated once, on the update path.
- Table storage is register arrays, not a RAM macro, because the read is asynchronous.

## Test plan
- **Reset:** after reset, LookupPC=0x40 → PredTaken=0 and PredNextPC=0x44; both stats read 0.
- **Cold miss:** UpdateEN with PC=0x40, branch, taken, target 0x100, predicted next PC 0x44 → Mispredict=1 and RecoverPC=0x100.
  - Next cycle, lookup 0x40 → PredTaken=1 and PredNextPC=0x100.
- **Training:** starting from ctr=10 for 0x40, apply two not-taken updates.
  - After the first: PredTaken=0.
  - After the second: the counter reads 00.
  - Three taken updates then return it to 11, and PredTaken=1 from the second taken update onward.
- **Aliasing:** with ENTRIES=16, a taken update at PC 0x40 and then a taken update at 0x80 (same index, different tag) → a lookup of 0x40 misses, PredNextPC=0x44.
- **Same-cycle collision:** a taken allocation update at 0x40 while LookupPC=0x40 → PredTaken=0 that cycle and 1 the next.
- **Saturation and reset priority:**
  - With STAT_W=4, 20 mispredicting updates → MispredCount=15.
  - RESET asserted together with UpdateEN → the table stays empty.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: direction-counter encodings and the BTB entry layout.
// Entry fields are sized at the widest supported PC; the predictor uses only the low bits.
package cpu_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = CTR_WNT;

    localparam int BTB_FIELD_W = 64;

    typedef struct packed {
        logic                   valid;
        logic [BTB_FIELD_W-1:0] tag;
        logic [BTB_FIELD_W-1:0] target;
        ctr_t                   ctr;
    } btb_entry_t;

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating direction counter next-state function; purely combinational.
// force_strong overrides the count and jumps straight to strong-taken.
module sat_counter2
    import cpu_pkg::*;
(
    input  ctr_t ctr_in,
    input  logic taken,
    input  logic force_strong,
    output ctr_t ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (force_strong) begin
            ctr_out = CTR_ST;
        end else if (taken) begin
            if (ctr_in != CTR_ST) ctr_out = ctr_t'(ctr_in + 2'd1);
        end else begin
            if (ctr_in != CTR_SNT) ctr_out = ctr_t'(ctr_in - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters; zero-latency lookup,
// training and misprediction detection on resolved branches, saturating statistics.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int STAT_W  = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] LookupPC,
    output logic              PredTaken,
    output logic [ADDR_W-1:0] PredNextPC,
    input  logic              UpdateEN,
    input  logic [ADDR_W-1:0] UpdatePC,
    input  logic              UpdateIsJump,
    input  logic              UpdateTaken,
    input  logic [ADDR_W-1:0] UpdateTarget,
    input  logic              UpdatePredTaken,
    input  logic [ADDR_W-1:0] UpdatePredNextPC,
    output logic              Mispredict,
    output logic [ADDR_W-1:0] RecoverPC,
    output logic [STAT_W-1:0] UpdateCount,
    output logic [STAT_W-1:0] MispredCount
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    btb_entry_t btb [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    btb_entry_t       lk_ent, up_ent, new_ent;
    logic             lk_hit, up_hit, wr_en;
    ctr_t             hit_ctr;
    logic [ADDR_W-1:0] actual_npc;

    assign lk_idx = LookupPC[IDX_W+1:2];
    assign lk_tag = LookupPC[ADDR_W-1:IDX_W+2];
    assign up_idx = UpdatePC[IDX_W+1:2];
    assign up_tag = UpdatePC[ADDR_W-1:IDX_W+2];

    // Lookup reads the registered table, so a same-cycle update is not visible here.
    assign lk_ent     = btb[lk_idx];
    assign lk_hit     = lk_ent.valid && (lk_ent.tag == BTB_FIELD_W'(lk_tag));
    assign PredTaken  = lk_hit && (lk_ent.ctr inside {CTR_WT, CTR_ST});
    assign PredNextPC = PredTaken ? lk_ent.target[ADDR_W-1:0] : LookupPC + ADDR_W'(4);

    assign up_ent = btb[up_idx];
    assign up_hit = up_ent.valid && (up_ent.tag == BTB_FIELD_W'(up_tag));

    sat_counter2 u_ctr (
        .ctr_in       (up_ent.ctr),
        .taken        (UpdateTaken),
        .force_strong (UpdateIsJump),
        .ctr_out      (hit_ctr)
    );

    always_comb begin
        new_ent = up_ent;
        wr_en   = 1'b0;
        if (UpdateEN) begin
            if (up_hit) begin
                wr_en       = 1'b1;
                new_ent.ctr = hit_ctr;
                if (UpdateTaken || UpdateIsJump)
                    new_ent.target = BTB_FIELD_W'(UpdateTarget);
            end else if (UpdateTaken) begin
                // Allocation evicts whatever occupied this index.
                wr_en          = 1'b1;
                new_ent.valid  = 1'b1;
                new_ent.tag    = BTB_FIELD_W'(up_tag);
                new_ent.target = BTB_FIELD_W'(UpdateTarget);
                new_ent.ctr    = UpdateIsJump ? CTR_ST : CTR_WT;
            end
        end
    end

    assign actual_npc = UpdateTaken ? UpdateTarget : UpdatePC + ADDR_W'(4);
    assign RecoverPC  = actual_npc;
    assign Mispredict = UpdateEN && (UpdatePredNextPC != actual_npc);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i].valid <= 1'b0;
                btb[i].ctr   <= CTR_RESET;
            end
            UpdateCount  <= '0;
            MispredCount <= '0;
        end else begin
            if (wr_en) btb[up_idx] <= new_ent;
            if (UpdateEN && (UpdateCount != {STAT_W{1'b1}}))
                UpdateCount <= UpdateCount + STAT_W'(1);
            if (Mispredict && (MispredCount != {STAT_W{1'b1}}))
                MispredCount <= MispredCount + STAT_W'(1);
        end
    end

    // The fetch-time direction bit is implied by the carried next PC.
    logic unused_bits;
    assign unused_bits = ^{UpdatePredTaken, lk_ent.target};

endmodule

// File: tb/tb_branch_predictor.sv
// Directed stimulus for branch_predictor; expected values are queued per cycle
// and checked by an independent negedge monitor.
module tb_branch_predictor;

    localparam int ADDR_W = 32;
    localparam int STAT_W = 4;

    logic              CLOCK = 1'b0;
    logic              RESET;
    logic [ADDR_W-1:0] LookupPC;
    logic              PredTaken;
    logic [ADDR_W-1:0] PredNextPC;
    logic              UpdateEN;
    logic [ADDR_W-1:0] UpdatePC;
    logic              UpdateIsJump;
    logic              UpdateTaken;
    logic [ADDR_W-1:0] UpdateTarget;
    logic              UpdatePredTaken;
    logic [ADDR_W-1:0] UpdatePredNextPC;
    logic              Mispredict;
    logic [ADDR_W-1:0] RecoverPC;
    logic [STAT_W-1:0] UpdateCount;
    logic [STAT_W-1:0] MispredCount;

    branch_predictor #(.ENTRIES(16), .ADDR_W(ADDR_W), .STAT_W(STAT_W)) dut (
        .CLOCK            (CLOCK),
        .RESET            (RESET),
        .LookupPC         (LookupPC),
        .PredTaken        (PredTaken),
        .PredNextPC       (PredNextPC),
        .UpdateEN         (UpdateEN),
        .UpdatePC         (UpdatePC),
        .UpdateIsJump     (UpdateIsJump),
        .UpdateTaken      (UpdateTaken),
        .UpdateTarget     (UpdateTarget),
        .UpdatePredTaken  (UpdatePredTaken),
        .UpdatePredNextPC (UpdatePredNextPC),
        .Mispredict       (Mispredict),
        .RecoverPC        (RecoverPC),
        .UpdateCount      (UpdateCount),
        .MispredCount     (MispredCount)
    );

    always #5 CLOCK = ~CLOCK;

    typedef enum int { K_PT, K_NPC, K_MISP, K_REC, K_UC, K_MC } kind_t;
    typedef struct {
        int          cyc;
        kind_t       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(negedge CLOCK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            n_vec++;
            case (e.kind)
                K_PT:    act = 32'(PredTaken);
                K_NPC:   act = PredNextPC;
                K_MISP:  act = 32'(Mispredict);
                K_REC:   act = RecoverPC;
                K_UC:    act = 32'(UpdateCount);
                default: act = 32'(MispredCount);
            endcase
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL %s: missed its cycle %0d (now %0d)", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", e.name, cyc, act, e.val);
            end
        end
    end

    task automatic drive(input logic rst, input logic [31:0] lpc, input logic en,
                         input logic [31:0] upc, input logic jmp, input logic tk,
                         input logic [31:0] tgt, input logic [31:0] pnpc);
        @(posedge CLOCK);
        #1;
        RESET            = rst;
        LookupPC         = lpc;
        UpdateEN         = en;
        UpdatePC         = upc;
        UpdateIsJump     = jmp;
        UpdateTaken      = tk;
        UpdateTarget     = tgt;
        UpdatePredNextPC = pnpc;
        UpdatePredTaken  = (pnpc != upc + 32'd4);
    endtask

    task automatic idle(input logic [31:0] lpc);
        drive(1'b0, lpc, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic ex(input kind_t k, input logic [31:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1; LookupPC = '0; UpdateEN = 1'b0; UpdatePC = '0; UpdateIsJump = 1'b0;
        UpdateTaken = 1'b0; UpdateTarget = '0; UpdatePredTaken = 1'b0; UpdatePredNextPC = '0;

        drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h40, 0, 0, 0, 0, 0, 0);

        idle(32'h40);
        ex(K_PT, 0, "reset_pt"); ex(K_NPC, 32'h44, "reset_npc"); ex(K_MISP, 0, "reset_misp");
        ex(K_UC, 0, "reset_uc"); ex(K_MC, 0, "reset_mc");

        // Cold miss, taken: allocates; lookup in the same cycle still misses.
        drive(0, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h44);
        ex(K_MISP, 1, "cold_misp"); ex(K_REC, 32'h100, "cold_rec");
        ex(K_PT, 0, "collide_pt"); ex(K_NPC, 32'h44, "collide_npc");
        idle(32'h40);
        ex(K_PT, 1, "alloc_pt"); ex(K_NPC, 32'h100, "alloc_npc");
        ex(K_UC, 1, "alloc_uc"); ex(K_MC, 1, "alloc_mc");

        // Training: WT -> WNT -> SNT -> WNT -> WT -> ST
        drive(0, 32'h40, 1, 32'h40, 0, 0, 32'h100, 32'h100);
        ex(K_PT, 1, "nt1_pt"); ex(K_MISP, 1, "nt1_misp"); ex(K_REC, 32'h44, "nt1_rec");
        drive(0, 32'h40, 1, 32'h40, 0, 0, 32'h100, 32'h44);
        ex(K_PT, 0, "nt2_pt"); ex(K_NPC, 32'h44, "nt2_npc"); ex(K_MISP, 0, "nt2_misp");
        drive(0, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h44);
        ex(K_PT, 0, "t1_pt"); ex(K_MISP, 1, "t1_misp"); ex(K_REC, 32'h100, "t1_rec");
        drive(0, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h44);
        ex(K_PT, 0, "t2_pt_from_snt"); ex(K_MISP, 1, "t2_misp");
        drive(0, 32'h40, 1, 32'h40, 0, 1, 32'h100, 32'h100);
        ex(K_PT, 1, "t3_pt"); ex(K_NPC, 32'h100, "t3_npc"); ex(K_MISP, 0, "t3_misp");
        idle(32'h40);
        ex(K_PT, 1, "st_pt"); ex(K_UC, 6, "train_uc"); ex(K_MC, 4, "train_mc");

        // One not-taken from strong-taken still predicts taken.
        drive(0, 32'h40, 1, 32'h40, 0, 0, 32'h100, 32'h100);
        ex(K_MISP, 1, "st_nt_misp"); ex(K_REC, 32'h44, "st_nt_rec");
        // Right direction, wrong target.
        drive(0, 32'h40, 1, 32'h40, 0, 1, 32'h200, 32'h100);
        ex(K_PT, 1, "wt_pt"); ex(K_NPC, 32'h100, "wt_npc");
        ex(K_MISP, 1, "tgt_misp"); ex(K_REC, 32'h200, "tgt_rec");
        idle(32'h40);
        ex(K_PT, 1, "tgt_pt"); ex(K_NPC, 32'h200, "tgt_npc");
        ex(K_UC, 8, "tgt_uc"); ex(K_MC, 6, "tgt_mc");

        // Jump allocation.
        drive(0, 32'h10, 1, 32'h10, 1, 1, 32'h300, 32'h14);
        ex(K_PT, 0, "jmp_pre_pt"); ex(K_NPC, 32'h14, "jmp_pre_npc");
        ex(K_MISP, 1, "jmp_misp"); ex(K_REC, 32'h300, "jmp_rec");
        idle(32'h10);
        ex(K_PT, 1, "jmp_pt"); ex(K_NPC, 32'h300, "jmp_npc");
        ex(K_UC, 9, "jmp_uc"); ex(K_MC, 7, "jmp_mc");

        // Miss, not taken: no allocation.
        drive(0, 32'h20, 1, 32'h20, 0, 0, 32'h999, 32'h24);
        ex(K_MISP, 0, "mnt_misp"); ex(K_REC, 32'h24, "mnt_rec");
        idle(32'h20);
        ex(K_PT, 0, "mnt_pt"); ex(K_NPC, 32'h24, "mnt_npc");
        ex(K_UC, 10, "mnt_uc"); ex(K_MC, 7, "mnt_mc");

        // Aliasing: 0x80 shares index 0 with 0x40 and evicts it.
        drive(0, 32'h40, 1, 32'h80, 0, 1, 32'h500, 32'h84);
        ex(K_PT, 1, "alias_pre_pt"); ex(K_NPC, 32'h200, "alias_pre_npc"); ex(K_MISP, 1, "alias_misp");
        idle(32'h40);
        ex(K_PT, 0, "alias_pt"); ex(K_NPC, 32'h44, "alias_npc");
        ex(K_UC, 11, "alias_uc"); ex(K_MC, 8, "alias_mc");
        idle(32'h80);
        ex(K_PT, 1, "alias_new_pt"); ex(K_NPC, 32'h500, "alias_new_npc");

        // PC+4 wraps modulo 2^32.
        drive(0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0);
        ex(K_NPC, 32'h0, "wrap_npc"); ex(K_MISP, 0, "wrap_misp"); ex(K_REC, 32'h0, "wrap_rec");

        // Statistics saturation (4-bit counters).
        for (int i = 0; i < 20; i++) begin
            drive(0, 32'h60, 1, 32'h60, 0, 0, 32'h0, 32'h999);
            ex(K_MISP, 1, "sat_misp");
        end
        idle(32'h60);
        ex(K_UC, 15, "sat_uc"); ex(K_MC, 15, "sat_mc"); ex(K_PT, 0, "sat_pt");

        // Reset wins over a simultaneous allocating update.
        drive(1, 32'h60, 1, 32'h60, 0, 1, 32'h700, 32'h64);
        idle(32'h60);
        ex(K_PT, 0, "rstpri_pt"); ex(K_NPC, 32'h64, "rstpri_npc");
        ex(K_UC, 0, "rstpri_uc"); ex(K_MC, 0, "rstpri_mc");
        idle(32'h80);
        ex(K_PT, 0, "rst_clear_pt"); ex(K_NPC, 32'h84, "rst_clear_npc");

        idle(32'h0);
        idle(32'h0);
        if (sb.size() != 0) begin
            n_bad += sb.size();
            $display("FAIL scoreboard: %0d expectations never checked", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
